// File: rtl/hazard_controller.sv
// Pipeline sequencer: load-use bubble, EX redirect flush, LSU-wait freeze with watchdog.
// Outputs combinational from state/inputs; LSU wait freezes upstream stages until mem_ack_i, ERR freezes all until reset.
module hazard_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [4:0]           id_rs1_addr_i,
  input  logic [4:0]           id_rs2_addr_i,
  input  logic                 id_rs1_used_i,
  input  logic                 id_rs2_used_i,
  input  logic [4:0]           ex_rd_addr_i,
  input  logic                 ex_rd_wren_i,
  input  logic                 ex_is_load_i,
  input  logic                 ex_redirect_i,
  input  logic                 mem_req_i,
  input  logic                 mem_ack_i,
  output logic                 pc_en_o,
  output logic                 if_id_en_o,
  output logic                 id_ex_en_o,
  output logic                 ex_mem_en_o,
  output logic                 mem_wb_en_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_flush_o,
  output logic                 mem_wb_bubble_o,
  output logic                 timeout_err_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t                state;
  logic [WW-1:0]         wait_cnt;
  logic                  err_q;
  logic [CNT_WIDTH-1:0]  stall_q;

  logic lu;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_bubble;

  always_comb begin
    lu = ex_is_load_i && ex_rd_wren_i && (ex_rd_addr_i != 5'd0) &&
         ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
          (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));
  end

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (state == ERR) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (mem_req_i && !mem_ack_i) begin
      // WB keeps draining with a bubble so the retiring instruction is not written twice
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_redirect_i) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // In MEM_WAIT mem_req_i is still held by the frozen MEM stage, so the shared
  // freeze condition above covers both states.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      stall_q  <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_req_i && !mem_ack_i) begin
            state    <= MEM_WAIT;
            wait_cnt <= WW'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ack_i) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WW'(TIMEOUT_CYCLES)) begin
            state <= ERR;
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        ERR: begin
          err_q <= 1'b1;
        end
        default: state <= RUN;
      endcase
      if (!pc_en && (state != ERR) && (stall_q != {CNT_WIDTH{1'b1}}))
        stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign pc_en_o         = pc_en         & rst_ni;
  assign if_id_en_o      = if_id_en      & rst_ni;
  assign id_ex_en_o      = id_ex_en      & rst_ni;
  assign ex_mem_en_o     = ex_mem_en     & rst_ni;
  assign mem_wb_en_o     = mem_wb_en     & rst_ni;
  assign if_id_flush_o   = if_id_flush   & rst_ni;
  assign id_ex_flush_o   = id_ex_flush   & rst_ni;
  assign mem_wb_bubble_o = mem_wb_bubble & rst_ni;
  assign timeout_err_o   = err_q;
  assign stall_cycles_o  = stall_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: load-use, redirect, LSU wait, timeout, saturation.
module tb_hazard_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1, rs2, rd;
  logic rs1_used, rs2_used, wren, is_load, redirect, req, ack;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, bubble, err;
  logic [31:0] stall;

  logic s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
  logic s_if_id_flush, s_id_ex_flush, s_bubble, s_err;
  logic [3:0] s_stall;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] DEF  = 8'b11111_000;
  localparam logic [7:0] LU   = 8'b00111_010;
  localparam logic [7:0] RED  = 8'b11111_110;
  localparam logic [7:0] FRZ  = 8'b00001_001;
  localparam logic [7:0] ZERO = 8'b00000_000;

  always #5 clk = ~clk;

  hazard_controller #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .ex_rd_addr_i(rd), .ex_rd_wren_i(wren), .ex_is_load_i(is_load),
    .ex_redirect_i(redirect), .mem_req_i(req), .mem_ack_i(ack),
    .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_ex_en_o(id_ex_en),
    .ex_mem_en_o(ex_mem_en), .mem_wb_en_o(mem_wb_en),
    .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
    .mem_wb_bubble_o(bubble), .timeout_err_o(err), .stall_cycles_o(stall)
  );

  hazard_controller #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(4)) dut_small (
    .clk_i(clk), .rst_ni(rst_n),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .ex_rd_addr_i(rd), .ex_rd_wren_i(wren), .ex_is_load_i(is_load),
    .ex_redirect_i(redirect), .mem_req_i(req), .mem_ack_i(ack),
    .pc_en_o(s_pc_en), .if_id_en_o(s_if_id_en), .id_ex_en_o(s_id_ex_en),
    .ex_mem_en_o(s_ex_mem_en), .mem_wb_en_o(s_mem_wb_en),
    .if_id_flush_o(s_if_id_flush), .id_ex_flush_o(s_id_ex_flush),
    .mem_wb_bubble_o(s_bubble), .timeout_err_o(s_err), .stall_cycles_o(s_stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, bubble};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    rs1_used = 1'b0; rs2_used = 1'b0; wren = 1'b0; is_load = 1'b0;
    redirect = 1'b0; req = 1'b0; ack = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    clr_in();
    rst_n = 1'b0;
    #3;
    chk_ctl("reset_ctl", ZERO);
    chk("reset_stall", stall, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    settle();
    chk_ctl("idle", DEF);
    cyc();

    // load x5 in EX, ID reads rs2=x5
    is_load = 1'b1; wren = 1'b1; rd = 5'd5; rs2 = 5'd5; rs2_used = 1'b1;
    settle(); chk_ctl("lu_rs2", LU);
    cyc();
    is_load = 1'b0;
    settle(); chk_ctl("lu_after", DEF); chk("lu_stall", stall, 32'd1);
    cyc();

    is_load = 1'b1; rd = 5'd0; rs2 = 5'd0;
    settle(); chk_ctl("lu_x0", DEF);
    cyc();
    rd = 5'd5; rs2 = 5'd5; rs2_used = 1'b0;
    settle(); chk_ctl("lu_unused", DEF);
    cyc();
    rs1 = 5'd5; rs1_used = 1'b1;
    settle(); chk_ctl("lu_rs1", LU);
    cyc();
    redirect = 1'b1;
    settle(); chk_ctl("lu_redirect", RED);
    cyc();
    clr_in();
    settle(); chk("redirect_stall", stall, 32'd2);
    cyc();

    // LSU wait: ack arrives on the fourth cycle
    req = 1'b1;
    settle(); chk_ctl("mw_frz0", FRZ);
    cyc();
    settle(); chk_ctl("mw_frz1", FRZ);
    cyc();
    settle(); chk_ctl("mw_frz2", FRZ);
    cyc();
    ack = 1'b1;
    settle(); chk_ctl("mw_ack", DEF);
    cyc();
    clr_in();
    settle(); chk_ctl("mw_run", DEF); chk("mw_stall", stall, 32'd5);
    cyc();
    req = 1'b1; ack = 1'b1;
    settle(); chk_ctl("mw_same_ack", DEF);
    cyc();
    ack = 1'b0;
    settle(); chk("same_ack_stall", stall, 32'd5); chk_ctl("mw2_frz", FRZ);
    cyc();
    // ack cycle in MEM_WAIT still applies the load-use rule
    ack = 1'b1; is_load = 1'b1; wren = 1'b1; rd = 5'd7; rs1 = 5'd7; rs1_used = 1'b1;
    settle(); chk_ctl("mw_ack_lu", LU);
    cyc();
    clr_in();
    settle(); chk("ack_lu_stall", stall, 32'd7); chk("small_stall7", {28'd0, s_stall}, 32'd7);
    cyc();

    // watchdog: 1 RUN freeze cycle plus 16 MEM_WAIT cycles, then ERR
    req = 1'b1;
    for (int i = 0; i < 17; i++) begin
      settle();
      chk_ctl("to_frz", FRZ);
      chk("to_no_err", {31'd0, err}, 32'd0);
      cyc();
    end
    settle();
    chk("to_err", {31'd0, err}, 32'd1);
    chk_ctl("to_err_ctl", ZERO);
    chk("to_stall", stall, 32'd24);
    chk("small_sat", {28'd0, s_stall}, 32'd15);
    cyc();
    ack = 1'b1;
    cyc();
    cyc();
    settle();
    chk("err_sticky", {31'd0, err}, 32'd1);
    chk_ctl("err_ack_ignored", ZERO);
    chk("err_stall_frozen", stall, 32'd24);
    chk("small_sat_hold", {28'd0, s_stall}, 32'd15);

    rst_n = 1'b0;
    #1;
    chk_ctl("rst_err_ctl", ZERO);
    chk("rst_err_clr", {31'd0, err}, 32'd0);
    chk("rst_stall_clr", stall, 32'd0);
    clr_in();
    settle();
    rst_n = 1'b1;
    cyc();
    settle(); chk_ctl("post_rst_run", DEF);
    cyc();

    // reset in the middle of an LSU wait must clear the wait counter
    req = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk_ctl("rst_mw_ctl", ZERO);
    chk("rst_mw_stall", stall, 32'd0);
    req = 1'b0;
    settle();
    rst_n = 1'b1;
    cyc();
    settle(); chk_ctl("rst_mw_run", DEF);
    cyc();
    req = 1'b1;
    repeat (16) cyc();
    settle();
    chk("rearm_no_err", {31'd0, err}, 32'd0);
    chk_ctl("rearm_frz", FRZ);
    cyc();
    settle();
    chk("rearm_err", {31'd0, err}, 32'd1);
    chk("rearm_stall", stall, 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
